multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK input 1 (rising edge); RST input 1 (synchronous, active-high).
REQ-002 op input 6: opcode from the instruction register; stable from ID until the next IF.
REQ-003 zero input 1: ALU zero flag, sampled in BEXE.
REQ-004 state output 3: current state code, consumed by the register file for write qualification.
REQ-005 PCWre output 1: the PC loads on the next rising CLK edge.
REQ-006 IRWre output 1: the instruction register loads.
REQ-007 InsMemRW output 1: instruction memory read.
REQ-008 RegWre output 1: register-file write enable.
REQ-009 RegDst output 2: write-register select; 00 = $31, 01 = rt, 10 = rd.
REQ-010 WrRegDSrc output 1: write-data select; 0 = PC+4, 1 = data bus.
REQ-011 DBDataSrc output 1: data-bus select; 0 = ALU result, 1 = RAM data-out.
REQ-012 ALUSrcB output 1: ALU operand B select; 0 = rt, 1 = extended immediate.
REQ-013 ExtSel output 1: 0 = zero-extend, 1 = sign-extend.
REQ-014 ALUOp output 3: 000 add, 001 sub, 010 slt, 100 and, 101 or.
REQ-015 mRD output 1: data-RAM read. mWR output 1: data-RAM write.
REQ-016 PCSrc output 2: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.

Function
REQ-017 State codes SHALL be: IF 000, ID 001, EXE 010, WB 011, MEM 100, BEXE 101, MEXE 110, HALT 111.
REQ-018 Opcodes SHALL be:
- add 000000, sub 000001, addiu 000010
- and 010000, andi 010001, ori 010010, slt 100110
- sw 110000, lw 110001, beq 110100, bne 110101
- j 111000, jr 111001, jal 111010, halt 111111
- Any other opcode is a NOP.
REQ-019 The state register SHALL update only on the rising CLK edge; all other outputs SHALL be combinational from state, op and zero.
REQ-020 IF: IRWre = 1 and InsMemRW = 1; next state is ID.
REQ-021 ID transitions:
- R-type/ALU-immediate -> EXE
- lw/sw -> MEXE
- beq/bne -> BEXE
- halt -> HALT
- j/jr/jal/NOP -> IF with PCWre = 1
REQ-022 ID PCSrc: j/jal 11, jr 10, NOP 00.
REQ-023 ID for jal: RegWre = 1, RegDst = 00, WrRegDSrc = 0, so the return address is written in state 001.
REQ-024 EXE -> WB: ALUSrcB = 1 for addiu/andi/ori; ExtSel = 0 for andi/ori, else 1; ALUOp per opcode.
REQ-025 WB -> IF: RegWre = 1, WrRegDSrc = 1, PCWre = 1, PCSrc = 00.
- RegDst = 10 for R-type, 01 for immediate ops and lw.
- DBDataSrc = 1 only for lw.
REQ-026 MEXE -> MEM: ALUOp = add, ALUSrcB = 1, ExtSel = 1.
REQ-027 MEM: lw asserts mRD = 1 and goes to WB; sw asserts mWR = 1 and goes to IF with PCWre = 1.
REQ-028 BEXE -> IF: ALUOp = sub, PCWre = 1.
- PCSrc = 01 if (beq and zero = 1) or (bne and zero = 0), else 00.
REQ-029 HALT SHALL self-loop with PCWre, RegWre, mWR and IRWre all 0; only RST exits HALT.
REQ-030 Outside the states that assert them: RegWre, mWR, mRD, PCWre and IRWre SHALL be 0; every other output SHALL be 0.
REQ-031 Instruction latency (cycles): R/imm 4, lw 5, sw 4, branch 3, j/jr/jal 2, NOP 2.

Reset
REQ-032 While RST = 1 at a rising edge, state SHALL become IF regardless of the current state, including mid-instruction and HALT.
REQ-033 While RST = 1, PCWre, RegWre, mWR and mRD SHALL be forced to 0.
REQ-034 After reset release, the first edge SHALL move IF -> ID.

Structure
REQ-035 A shared package ctrl_defs SHALL hold the state codes, opcodes, ALUOp codes and PCSrc/RegDst encodings.
REQ-036 One combinational sub-module, ctrl_decode, SHALL map (state, op, zero) to the control outputs.
- The top level holds only the state register and next-state logic.

Verification
REQ-037 Reset mid-MEM of lw: RST = 1 for 1 edge -> state = 000; mRD = 0 and RegWre = 0 during reset.
REQ-038 op = 000000 from reset -> states 000, 001, 010, 011, 000.
- WB cycle: RegWre = 1, RegDst = 10, DBDataSrc = 0.
- PCWre = 1 only in WB.
REQ-039 op = 110001 (lw) -> states 000, 001, 110, 100, 011.
- MEM: mRD = 1.
- WB: DBDataSrc = 1, RegDst = 01.
REQ-040 op = 110100 (beq): zero = 1 -> PCSrc = 01 in BEXE; zero = 0 -> PCSrc = 00; BEXE -> IF in both cases.
REQ-041 op = 111010 (jal) -> ID: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 11, PCWre = 1; next state = 000.
REQ-042 op = 111111 -> HALT holds for 10 cycles with PCWre = 0; RST = 1 -> state = 000.

Source files
------------

// File: rtl/ctrl_defs.sv
// Shared encodings for the multi-cycle CPU controller: state codes, opcodes,
// ALU operation codes and mux select values, plus opcode classification helpers.
package ctrl_defs;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_WB   = 3'b011,
    ST_MEM  = 3'b100,
    ST_BEXE = 3'b101,
    ST_MEXE = 3'b110,
    ST_HALT = 3'b111
  } stateT;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] REG_RA = 2'b00;
  localparam logic [1:0] REG_RT = 2'b01;
  localparam logic [1:0] REG_RD = 2'b10;

  function automatic logic isRType(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLT);
  endfunction

  function automatic logic isImm(input logic [5:0] op);
    return (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [2:0] aluOpFor(input logic [5:0] op);
    logic [2:0] aluOp;
    case (op)
      OP_SUB:          aluOp = ALU_SUB;
      OP_SLT:          aluOp = ALU_SLT;
      OP_AND, OP_ANDI: aluOp = ALU_AND;
      OP_ORI:          aluOp = ALU_OR;
      default:         aluOp = ALU_ADD;
    endcase
    return aluOp;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational control decode: maps the current state, opcode and ALU
// zero flag onto every datapath control line.
module ctrl_decode
  import ctrl_defs::*;
(
  input  stateT      state,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc
);

  logic isJump;
  logic takeBranch;

  assign isJump     = (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
  assign takeBranch = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    RegDst    = REG_RA;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = PC_NEXT;

    case (state)
      ST_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      // Jumps and NOPs retire from ID; jal writes its link register here.
      ST_ID: begin
        if (isJump || !(isRType(op) || isImm(op) || op == OP_LW || op == OP_SW ||
                        op == OP_BEQ || op == OP_BNE || op == OP_HALT)) begin
          PCWre = 1'b1;
          case (op)
            OP_J, OP_JAL: PCSrc = PC_JUMP;
            OP_JR:        PCSrc = PC_RS;
            default:      PCSrc = PC_NEXT;
          endcase
          if (op == OP_JAL) begin
            RegWre    = 1'b1;
            RegDst    = REG_RA;
            WrRegDSrc = 1'b0;
          end
        end
      end
      ST_EXE: begin
        ALUSrcB = isImm(op);
        ExtSel  = !((op == OP_ANDI) || (op == OP_ORI));
        ALUOp   = aluOpFor(op);
      end
      ST_WB: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        RegDst    = isRType(op) ? REG_RD : REG_RT;
        DBDataSrc = (op == OP_LW);
      end
      ST_MEXE: begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
      end
      ST_MEM: begin
        mRD   = (op == OP_LW);
        mWR   = (op == OP_SW);
        PCWre = (op == OP_SW);
      end
      ST_BEXE: begin
        ALUOp = ALU_SUB;
        PCWre = 1'b1;
        PCSrc = takeBranch ? PC_BRANCH : PC_NEXT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller top: state register plus next-state logic; the
// control lines come from ctrl_decode, with write strobes held off during reset.
module multi_cycle_ctrl
  import ctrl_defs::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc
);

  stateT stateReg;
  stateT nextState;
  logic  decPCWre;
  logic  decRegWre;
  logic  decMRD;
  logic  decMWR;

  always_ff @(posedge CLK) begin
    if (RST) stateReg <= ST_IF;
    else     stateReg <= nextState;
  end

  always_comb begin
    nextState = ST_IF;
    case (stateReg)
      ST_IF: nextState = ST_ID;
      ST_ID: begin
        if (isRType(op) || isImm(op))           nextState = ST_EXE;
        else if (op == OP_LW || op == OP_SW)    nextState = ST_MEXE;
        else if (op == OP_BEQ || op == OP_BNE)  nextState = ST_BEXE;
        else if (op == OP_HALT)                 nextState = ST_HALT;
        else                                    nextState = ST_IF;
      end
      ST_EXE:  nextState = ST_WB;
      ST_MEXE: nextState = ST_MEM;
      ST_MEM:  nextState = (op == OP_LW) ? ST_WB : ST_IF;
      ST_HALT: nextState = ST_HALT;
      default: nextState = ST_IF;
    endcase
  end

  ctrl_decode uDecode (
    .state     (stateReg),
    .op        (op),
    .zero      (zero),
    .PCWre     (decPCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (decRegWre),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .DBDataSrc (DBDataSrc),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .ALUOp     (ALUOp),
    .mRD       (decMRD),
    .mWR       (decMWR),
    .PCSrc     (PCSrc)
  );

  // A reset arriving mid-instruction must not let a half-finished store or write land.
  assign state  = stateReg;
  assign PCWre  = decPCWre  & ~RST;
  assign RegWre = decRegWre & ~RST;
  assign mRD    = decMRD    & ~RST;
  assign mWR    = decMWR    & ~RST;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: each scenario queues the expected
// per-cycle control vector and compares it against the DUT cycle by cycle.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;
    logic [1:0] PCSrc;
  } outT;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] op = 6'b000000;
  logic       zero = 1'b0;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel, mRD, mWR;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  int  errors = 0;
  int  checks = 0;
  outT expQ[$];

  multi_cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .op(op), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .PCSrc(PCSrc)
  );

  always #5 CLK = ~CLK;

  function automatic outT sampleOut();
    outT s;
    s = {state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, DBDataSrc,
         ALUSrcB, ExtSel, ALUOp, mRD, mWR, PCSrc};
    return s;
  endfunction

  function automatic outT mk(input logic [2:0] st);
    outT e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic outT expIF();
    outT e;
    e = mk(3'b000);
    e.IRWre = 1'b1;
    e.InsMemRW = 1'b1;
    return e;
  endfunction

  function automatic outT expWB(input logic [1:0] dst, input logic fromRam);
    outT e;
    e = mk(3'b011);
    e.RegWre = 1'b1;
    e.WrRegDSrc = 1'b1;
    e.PCWre = 1'b1;
    e.RegDst = dst;
    e.DBDataSrc = fromRam;
    return e;
  endfunction

  function automatic outT expEXE(input logic srcB, input logic ext, input logic [2:0] alu);
    outT e;
    e = mk(3'b010);
    e.ALUSrcB = srcB;
    e.ExtSel = ext;
    e.ALUOp = alu;
    return e;
  endfunction

  function automatic outT expMEXE();
    outT e;
    e = mk(3'b110);
    e.ALUSrcB = 1'b1;
    e.ExtSel = 1'b1;
    return e;
  endfunction

  task automatic stepClk();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    outT exp, act;
    RST = 1'b1;
    stepClk();
    stepClk();
    exp = expIF();
    act = sampleOut();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", act, exp);
    end
    RST = 1'b0;
  endtask

  task automatic test_rtype(input logic [5:0] opc, input logic [2:0] alu, input string name);
    outT exp, act;
    op = opc;
    expQ.push_back(expIF());
    expQ.push_back(mk(3'b001));
    expQ.push_back(expEXE(1'b0, 1'b1, alu));
    expQ.push_back(expWB(2'b10, 1'b0));
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = sampleOut();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
      stepClk();
    end
  endtask

  task automatic test_imm(input logic [5:0] opc, input logic ext, input logic [2:0] alu,
                          input string name);
    outT exp, act;
    op = opc;
    expQ.push_back(expIF());
    expQ.push_back(mk(3'b001));
    expQ.push_back(expEXE(1'b1, ext, alu));
    expQ.push_back(expWB(2'b01, 1'b0));
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = sampleOut();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
      stepClk();
    end
  endtask

  task automatic test_lw_sw();
    outT exp, act, e;
    op = 6'b110001;
    expQ.push_back(expIF());
    expQ.push_back(mk(3'b001));
    expQ.push_back(expMEXE());
    e = mk(3'b100); e.mRD = 1'b1;
    expQ.push_back(e);
    expQ.push_back(expWB(2'b01, 1'b1));
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = sampleOut();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL lw: got %h expected %h", act, exp);
      end
      stepClk();
    end
    op = 6'b110000;
    expQ.push_back(expIF());
    expQ.push_back(mk(3'b001));
    expQ.push_back(expMEXE());
    e = mk(3'b100); e.mWR = 1'b1; e.PCWre = 1'b1;
    expQ.push_back(e);
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = sampleOut();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL sw: got %h expected %h", act, exp);
      end
      stepClk();
    end
  endtask

  task automatic test_branch();
    outT exp, act, e;
    logic [5:0] ops[4] = '{6'b110100, 6'b110100, 6'b110101, 6'b110101};
    logic       zs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] pcs[4] = '{2'b01, 2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      op = ops[i];
      zero = zs[i];
      expQ.push_back(expIF());
      expQ.push_back(mk(3'b001));
      e = mk(3'b101); e.ALUOp = 3'b001; e.PCWre = 1'b1; e.PCSrc = pcs[i];
      expQ.push_back(e);
      while (expQ.size() > 0) begin
        exp = expQ.pop_front();
        act = sampleOut();
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL branch%0d: got %h expected %h", i, act, exp);
        end
        stepClk();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    outT exp, act, e;
    logic [5:0] ops[4] = '{6'b111000, 6'b111001, 6'b111010, 6'b001111};
    logic [1:0] pcs[4] = '{2'b11, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      op = ops[i];
      expQ.push_back(expIF());
      e = mk(3'b001); e.PCWre = 1'b1; e.PCSrc = pcs[i];
      if (i == 2) begin
        e.RegWre = 1'b1;
        e.RegDst = 2'b00;
        e.WrRegDSrc = 1'b0;
      end
      expQ.push_back(e);
      while (expQ.size() > 0) begin
        exp = expQ.pop_front();
        act = sampleOut();
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL jump%0d: got %h expected %h", i, act, exp);
        end
        stepClk();
      end
    end
  endtask

  task automatic test_reset_mid_lw();
    outT exp, act;
    op = 6'b110001;
    expQ.push_back(expIF());
    expQ.push_back(mk(3'b001));
    expQ.push_back(expMEXE());
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = sampleOut();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL midlw_pre: got %h expected %h", act, exp);
      end
      stepClk();
    end
    RST = 1'b1;
    #1;
    exp = mk(3'b100);
    act = sampleOut();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL midlw_mem_in_reset: got %h expected %h", act, exp);
    end
    stepClk();
    exp = expIF();
    act = sampleOut();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL midlw_after_reset: got %h expected %h", act, exp);
    end
    RST = 1'b0;
  endtask

  task automatic test_halt();
    outT exp, act;
    op = 6'b111111;
    expQ.push_back(expIF());
    expQ.push_back(mk(3'b001));
    for (int i = 0; i < 10; i++) expQ.push_back(mk(3'b111));
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = sampleOut();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL halt: got %h expected %h", act, exp);
      end
      stepClk();
    end
    RST = 1'b1;
    stepClk();
    exp = expIF();
    act = sampleOut();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL halt_exit: got %h expected %h", act, exp);
    end
    RST = 1'b0;
  endtask

  initial begin
    $display("[TB] multi_cycle_ctrl bench start");
    test_reset();
    test_rtype(6'b000000, 3'b000, "add");
    test_rtype(6'b000001, 3'b001, "sub");
    test_rtype(6'b010000, 3'b100, "and");
    test_rtype(6'b100110, 3'b010, "slt");
    test_imm(6'b000010, 1'b1, 3'b000, "addiu");
    test_imm(6'b010001, 1'b0, 3'b100, "andi");
    test_imm(6'b010010, 1'b0, 3'b101, "ori");
    test_lw_sw();
    test_branch();
    test_jumps();
    test_reset_mid_lw();
    test_rtype(6'b000000, 3'b000, "add_after_reset");
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
